ib_rx_fifo: RTL and testbench
=============================

# ib_rx_fifo

Byte FIFO and flow-control stage between the host-side UART receiver and the IB I/O-expander transponder. Absorbs bursts of host bytes arriving as single-cycle strobes. Presents them one at a time to the transponder on its four-phase data/available/ack_n handshake. Drives the host RTS line with hysteresis so the host stops sending before storage overflows.

## Interface
- DEPTH, 16: storage entries; power of two, at least 4.
- RTS_HI, 12: stop level; `rts` is set when the stored count is ≥ RTS_HI.
- RTS_LO, 4: resume level; `rts` is cleared when the stored count is ≤ RTS_LO. Constraint: RTS_LO < RTS_HI ≤ DEPTH.

- clk  in  1  system clock (7.3728 MHz).
- rst  in  1  synchronous, active-high reset.
- in_data  in  8  received byte; valid only when `in_valid` is high.
- in_valid  in  1  single-cycle strobe: a byte is presented this cycle.
- out_data  out  8  byte offered to the transponder.
- out_available  out  1  high while `out_data` is being offered.
- out_ack_n  in  1  transponder acknowledge, active low; synchronous to `clk`.
- rts  out  1  host flow control: 0 = host may send, 1 = host must stop.
- overflow  out  1  sticky flag: a byte was dropped; cleared only by `rst`.
- count  out  $clog2(DEPTH)+1  bytes held in storage. Excludes the byte in the output register.

## Operation
- **Storage.** Circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a separate `count` register.
- **Push.**
  - `in_valid` with count < DEPTH: write at the write pointer and advance it.
  - `in_valid` with count == DEPTH and a pop in the same cycle: the byte is accepted.
  - `in_valid` with count == DEPTH and no pop: the byte is dropped, `overflow` is set to 1, and pointers and count are unchanged.
- **Pop.** Performed only by the output FSM, only from IDLE. Moves the head byte into the `out_data` register. No bypass: a byte pushed into empty storage cannot be popped in the same cycle.
- **Count update.** count_next = count + push_accepted − pop.
- **Output FSM** (three states):
  - IDLE: `out_available` = 0. If count ≠ 0 and `out_ack_n` == 1, pop into `out_data` and go to OFFER.
  - OFFER: `out_available` = 1 and `out_data` is held. On `out_ack_n` == 0, go to RELEASE.
  - RELEASE: `out_available` = 0 and `out_data` is held. On `out_ack_n` == 1, go to IDLE.
- **Byte ordering.** Bytes leave in arrival order. Each byte is offered exactly once.
- **Stuck-low acknowledge.** If `out_ack_n` is low while the FSM is in IDLE, nothing is offered until it returns high.
- **Effective capacity.** DEPTH stored bytes plus one byte in the output register.
- **RTS.** Registered, computed from the registered `count`. Set to 1 when count ≥ RTS_HI. Cleared to 0 when count ≤ RTS_LO. Holds its value between the two levels.
- **Reset** (also when asserted mid-handshake): pointers 0, count 0, FSM to IDLE, `out_available` 0, `out_data` 0x00, `rts` 0, `overflow` 0. Any byte in flight is discarded.

## Timing
- All outputs are registered. `rst` wins over every other input in the same cycle.
- Push latency: `in_valid` in cycle N makes `count` increment visible in N+1.
- Empty-to-offer latency: with the FSM in IDLE and `out_ack_n` = 1, `out_available` rises in N+2 with `out_data` valid in that same cycle.
- OFFER → RELEASE: `out_available` falls in the cycle after `out_ack_n` is first sampled low.
- RELEASE → IDLE: the FSM enters IDLE in the cycle after `out_ack_n` is sampled high. The next offer can rise one cycle after that, so the minimum is 2 cycles between offers.
- `rts` lags `count` by one cycle. The host must tolerate at least DEPTH − RTS_HI further bytes after `rts` rises.
- In the same cycle, push and pop both operate on pre-edge state.

## Test plan
- **Reset values.** Assert `rst` for 2 cycles with `in_valid` = 1 → `out_available` 0, `out_data` 0x00, `count` 0, `rts` 0, `overflow` 0. No byte is stored.
- **Single byte.** Push 0xA5 at cycle N → `out_available` 1 with `out_data` 0xA5 at N+2. Drive ack_n low, then high → `out_available` drops one cycle after ack_n is sampled low, and `count` returns to 0.
- **Fill and overflow.** Hold `out_ack_n` high and never acknowledge. Push 0x00–0x10 back-to-back (17 bytes).
  - `out_data` = 0x00 and `count` = 16.
  - `rts` = 1 one cycle after `count` reaches 12.
  - `overflow` = 0.
  - An 18th push of 0x11 → `count` stays 16 and `overflow` = 1.
- **Drain.** Complete handshakes → the full sequence is delivered in order with no duplicates. `rts` returns to 0 one cycle after `count` ≤ 4.
- **Full with simultaneous pop.** Push a byte in the same cycle the FSM pops at `count` = 16 → the byte is accepted, `count` stays 16, and `overflow` stays 0.
- **Stuck ack and mid-handshake reset.**
  - Hold `out_ack_n` low from reset and push 0x3C → no offer is made; raising ack_n causes the offer 1 cycle later.
  - Then assert `rst` during OFFER → next cycle `out_available` is 0, `count` is 0, and 0x3C is never re-offered.

Source files
------------

// File: rtl/ib_rx_fifo_if.sv
// Handshake bundle between the host UART receiver, ib_rx_fifo and the IB transponder.
// Master drives the incoming byte strobe and the transponder acknowledge; slave is the FIFO.
interface ib_rx_fifo_if #(
  parameter int DATA_W = 8,
  parameter int CW     = 5
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_available;
  logic              out_ack_n;
  logic              rts;
  logic              overflow;
  logic [CW-1:0]     count;

  modport master (
    output in_data, in_valid, out_ack_n,
    input  out_data, out_available, rts, overflow, count
  );

  modport slave (
    input  in_data, in_valid, out_ack_n,
    output out_data, out_available, rts, overflow, count
  );
endinterface

// File: rtl/ib_rx_fifo.sv
// Byte FIFO between the host UART receiver and the IB transponder: circular storage,
// four-phase data/available/ack_n output handshake and RTS flow control with hysteresis.
module ib_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int RTS_HI = 12,
  parameter int RTS_LO = 4
) (
  input  logic          clk,
  input  logic          rst,
  ib_rx_fifo_if.slave   io
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] HI_C   = CW'(RTS_HI);
  localparam logic [CW-1:0] LO_C   = CW'(RTS_LO);

  typedef enum logic [1:0] {IDLE, OFFER, RELEASE} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_q;
  logic [DATA_W-1:0] out_data_q;
  logic              avail_q;
  logic              rts_q;
  logic              ovf_q;
  logic              pop;
  logic              push_ok;
  logic              drop;

  // Push and pop both see pre-edge state; a full buffer still accepts when a pop frees a slot.
  always_comb begin
    pop     = (state == IDLE) && (count_q != '0) && io.out_ack_n;
    push_ok = io.in_valid && ((count_q != FULL_C) || pop);
    drop    = io.in_valid && !push_ok;
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr] <= io.in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      out_data_q <= '0;
      avail_q    <= 1'b0;
      rts_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (drop)    ovf_q  <= 1'b1;

      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase

      // Hysteresis from the registered count, so rts trails count by one cycle.
      if (count_q >= HI_C)      rts_q <= 1'b1;
      else if (count_q <= LO_C) rts_q <= 1'b0;

      case (state)
        IDLE: begin
          if (pop) begin
            out_data_q <= mem[rd_ptr];
            rd_ptr     <= rd_ptr + AW'(1);
            avail_q    <= 1'b1;
            state      <= OFFER;
          end
        end
        OFFER: begin
          if (!io.out_ack_n) begin
            avail_q <= 1'b0;
            state   <= RELEASE;
          end
        end
        RELEASE: begin
          if (io.out_ack_n) state <= IDLE;
        end
        default: begin
          avail_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign io.out_data      = out_data_q;
  assign io.out_available = avail_q;
  assign io.rts           = rts_q;
  assign io.overflow      = ovf_q;
  assign io.count         = count_q;
endmodule

// File: tb/tb_ib_rx_fifo.sv
// Bench for ib_rx_fifo: queue-based reference model compared every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_ib_rx_fifo;
  localparam int DEPTH  = 16;
  localparam int RTS_HI = 12;
  localparam int RTS_LO = 4;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst;

  ib_rx_fifo_if #(.DATA_W(8), .CW(CW)) io ();

  ib_rx_fifo #(.DATA_W(8), .DEPTH(DEPTH), .RTS_HI(RTS_HI), .RTS_LO(RTS_LO)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  bit chk_en     = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: storage as a queue, the output slot as a held byte plus a phase
  // (0 nothing offered, 1 offering, 2 waiting for ack_n to return high).
  logic [7:0] mq[$];
  int         m_phase = 0;
  logic [7:0] m_data  = 8'h00;
  bit         m_rts   = 1'b0;
  bit         m_ovf   = 1'b0;

  always @(posedge clk) begin
    int n;
    bit take, acc;
    if (rst) begin
      mq.delete();
      m_phase = 0;
      m_data  = 8'h00;
      m_rts   = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      n    = mq.size();
      take = (m_phase == 0) && (n > 0) && (io.out_ack_n === 1'b1);
      acc  = (io.in_valid === 1'b1) && ((n < DEPTH) || take);
      if (n >= RTS_HI) m_rts = 1'b1;
      else if (n <= RTS_LO) m_rts = 1'b0;
      if ((io.in_valid === 1'b1) && !acc) m_ovf = 1'b1;
      case (m_phase)
        0: if (take) begin m_data = mq.pop_front(); m_phase = 1; end
        1: if (io.out_ack_n === 1'b0) m_phase = 2;
        default: if (io.out_ack_n === 1'b1) m_phase = 0;
      endcase
      if (acc) mq.push_back(io.in_data);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_avail", io.out_available, (m_phase == 1) ? 32'd1 : 32'd0);
      chk("model_data",  io.out_data, m_data);
      chk("model_count", io.count, 32'(mq.size()));
      chk("model_rts",   io.rts, m_rts);
      chk("model_ovf",   io.overflow, m_ovf);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic handshake(input logic [7:0] exp);
    for (int i = 0; i < 8 && io.out_available !== 1'b1; i++) tick();
    chk("hs_avail", io.out_available, 1);
    chk("hs_data", io.out_data, exp);
    io.out_ack_n = 1'b0;
    tick();
    chk("hs_release", io.out_available, 0);
    io.out_ack_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    io.in_valid  = 1'b1;
    io.in_data   = 8'hFF;
    io.out_ack_n = 1'b1;

    // Reset with a strobe present: nothing may be stored.
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_avail", io.out_available, 0);
    chk("rst_data", io.out_data, 8'h00);
    chk("rst_count", io.count, 0);
    chk("rst_rts", io.rts, 0);
    chk("rst_ovf", io.overflow, 0);
    rst = 1'b0;
    io.in_valid = 1'b0;
    tick();
    chk("rst_nostore", io.count, 0);

    // Single byte: offer two cycles after the push.
    io.in_valid = 1'b1;
    io.in_data  = 8'hA5;
    tick();
    io.in_valid = 1'b0;
    chk("single_count1", io.count, 1);
    chk("single_notyet", io.out_available, 0);
    tick();
    chk("single_avail", io.out_available, 1);
    chk("single_data", io.out_data, 8'hA5);
    io.out_ack_n = 1'b0;
    tick();
    chk("single_drop", io.out_available, 0);
    io.out_ack_n = 1'b1;
    tick();
    chk("single_count0", io.count, 0);
    tick();

    // Fill without acknowledging: 0x00 sits in the output register, 16 bytes stored.
    for (int k = 0; k <= 16; k++) begin
      io.in_valid = 1'b1;
      io.in_data  = 8'(k);
      tick();
      if (k == 12) begin
        chk("fill_count12", io.count, 12);
        chk("fill_rts_lag", io.rts, 0);
      end
      if (k == 13) chk("fill_rts_set", io.rts, 1);
    end
    chk("fill_data", io.out_data, 8'h00);
    chk("fill_count", io.count, 16);
    chk("fill_ovf", io.overflow, 0);
    io.in_data = 8'h11;
    tick();
    io.in_valid = 1'b0;
    chk("ovf_count", io.count, 16);
    chk("ovf_flag", io.overflow, 1);

    // Drain everything in order; the dropped 0x11 must never appear.
    for (int k = 0; k <= 16; k++) handshake(8'(k));
    chk("drain_count", io.count, 0);
    chk("drain_rts", io.rts, 0);
    repeat (3) tick();
    chk("drain_noextra", io.out_available, 0);

    // Stuck-low acknowledge from reset.
    rst = 1'b1;
    io.out_ack_n = 1'b0;
    tick();
    rst = 1'b0;
    io.in_valid = 1'b1;
    io.in_data  = 8'h3C;
    tick();
    io.in_valid = 1'b0;
    repeat (3) begin
      tick();
      chk("stuck_nooffer", io.out_available, 0);
    end
    chk("stuck_count", io.count, 1);
    io.out_ack_n = 1'b1;
    tick();
    chk("stuck_offer", io.out_available, 1);
    chk("stuck_data", io.out_data, 8'h3C);

    // Reset during OFFER discards the byte.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_avail", io.out_available, 0);
    chk("midrst_count", io.count, 0);
    chk("midrst_data", io.out_data, 8'h00);
    repeat (4) begin
      tick();
      chk("midrst_nooffer", io.out_available, 0);
    end

    // Full with simultaneous pop: ack_n low keeps IDLE from popping while filling.
    io.out_ack_n = 1'b0;
    for (int k = 0; k < 16; k++) begin
      io.in_valid = 1'b1;
      io.in_data  = 8'h40 + 8'(k);
      tick();
    end
    chk("fullpop_pre", io.count, 16);
    io.out_ack_n = 1'b1;
    io.in_data   = 8'h50;
    tick();
    io.in_valid = 1'b0;
    chk("fullpop_count", io.count, 16);
    chk("fullpop_ovf", io.overflow, 0);
    chk("fullpop_avail", io.out_available, 1);
    chk("fullpop_data", io.out_data, 8'h40);
    for (int k = 0; k <= 16; k++) handshake(8'h40 + 8'(k));
    chk("fullpop_drained", io.count, 0);
    tick();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
